// File: rtl/alu_seq_display.sv
// Clocked 4-op ALU (buffer/NAND/add/shift-add multiply) with a
// time-multiplexed hex readout on a multi-digit 7-segment display.
module alu_seq_display #(
  parameter  int WIDTH    = 4,
  parameter  int SCAN_DIV = 1024,
  localparam int RW       = 2 * WIDTH,
  localparam int DIGITS   = (RW + 3) / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [RW-1:0]     result,
  output logic [DIGITS-1:0] seg_sel,
  output logic [7:0]        seg_data
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [RW-1:0]    r_mcand;
  logic [RW-1:0]    r_acc;
  logic [CW-1:0]    r_iter;

  logic [WIDTH-1:0] w_nand;
  logic [WIDTH:0]   w_sum;
  logic [RW-1:0]    w_alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = (op == 2'b11) ? S_MUL : S_FIN;
      end
      S_MUL: begin
        if (r_iter == CW'(WIDTH - 1)) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_comb begin
    w_nand = ~(r_a & r_b);
    w_sum  = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    w_alu  = '0;
    unique case (r_op)
      2'b00: w_alu = {{WIDTH{1'b0}}, r_a};
      2'b01: w_alu = {{WIDTH{1'b0}}, w_nand};
      2'b10: w_alu = {{(WIDTH-1){1'b0}}, w_sum};
      2'b11: w_alu = r_acc;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_iter  <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= (r_state == S_FIN);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_cin   <= cin;
            r_mcand <= {{WIDTH{1'b0}}, a};
            r_acc   <= '0;
            r_iter  <= '0;
          end
        end
        S_MUL: begin
          // r_b doubles as the multiplier shift register
          if (r_b[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_b     <= r_b >> 1;
          r_iter  <= r_iter + CW'(1);
        end
        S_FIN:   result <= w_alu;
        default: ;
      endcase
    end
  end

  logic [SW-1:0]         r_scan;
  logic [IW-1:0]         r_idx;
  logic                  w_wrap;
  logic [IW-1:0]         w_idx_nxt;
  logic [DIGITS*4-1:0]   w_pad;
  logic [3:0]            w_nib;
  logic [7:0]            w_seg;

  always_comb begin
    w_wrap    = (r_scan == SW'(SCAN_DIV - 1));
    w_idx_nxt = r_idx;
    if (w_wrap) begin
      if (r_idx == IW'(DIGITS - 1)) w_idx_nxt = '0;
      else                          w_idx_nxt = r_idx + IW'(1);
    end
    w_pad          = '0;
    w_pad[RW-1:0]  = result;
    w_nib          = w_pad[{w_idx_nxt, 2'b00} +: 4];
  end

  always_comb begin
    w_seg = 8'h00;
    unique case (w_nib)
      4'h0: w_seg = 8'b00111111;
      4'h1: w_seg = 8'b00000110;
      4'h2: w_seg = 8'b01011011;
      4'h3: w_seg = 8'b01001111;
      4'h4: w_seg = 8'b01100110;
      4'h5: w_seg = 8'b01101101;
      4'h6: w_seg = 8'b01111101;
      4'h7: w_seg = 8'b00000111;
      4'h8: w_seg = 8'b01111111;
      4'h9: w_seg = 8'b01101111;
      4'hA: w_seg = 8'b01110111;
      4'hB: w_seg = 8'b01111100;
      4'hC: w_seg = 8'b00111001;
      4'hD: w_seg = 8'b01011110;
      4'hE: w_seg = 8'b01111001;
      4'hF: w_seg = 8'b01110001;
      default: w_seg = 8'h00;
    endcase
  end

  // Decode uses the upcoming digit so data and select switch together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan   <= '0;
      r_idx    <= '0;
      seg_sel  <= DIGITS'(1);
      seg_data <= 8'b00111111;
    end else begin
      r_scan   <= w_wrap ? '0 : r_scan + SW'(1);
      r_idx    <= w_idx_nxt;
      seg_sel  <= DIGITS'(1) << w_idx_nxt;
      seg_data <= w_seg;
    end
  end

endmodule

// File: tb/tb_alu_seq_display.sv
// Scoreboard bench for alu_seq_display: two instances (WIDTH 4 and 6),
// random ops vs an arithmetic reference model, plus display scan checks.
module tb_alu_seq_display;

  localparam int WD [2] = '{4, 6};
  localparam int SD [2] = '{4, 5};
  localparam int DG [2] = '{2, 3};
  localparam logic [7:0] SEG_TAB [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start_v [2];
  logic [1:0] op_v    [2];
  logic [5:0] a_v     [2];
  logic [5:0] b_v     [2];
  logic       cin_v   [2];

  logic        busy0, done0, busy1, done1;
  logic [7:0]  res0, seg0, seg1;
  logic [11:0] res1;
  logic [1:0]  sel0;
  logic [2:0]  sel1;

  alu_seq_display #(.WIDTH(4), .SCAN_DIV(4)) u_d0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .cin(cin_v[0]),
    .busy(busy0), .done(done0), .result(res0),
    .seg_sel(sel0), .seg_data(seg0));

  alu_seq_display #(.WIDTH(6), .SCAN_DIV(5)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v[1]),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
    .busy(busy1), .done(done1), .result(res1),
    .seg_sel(sel1), .seg_data(seg1));

  logic        busy_v [2];
  logic        done_v [2];
  logic [11:0] res_v  [2];
  logic [2:0]  sel_v  [2];
  logic [7:0]  seg_v  [2];
  assign busy_v[0] = busy0;
  assign busy_v[1] = busy1;
  assign done_v[0] = done0;
  assign done_v[1] = done1;
  assign res_v[0]  = {4'b0, res0};
  assign res_v[1]  = res1;
  assign sel_v[0]  = {1'b0, sel0};
  assign sel_v[1]  = sel1;
  assign seg_v[0]  = seg0;
  assign seg_v[1]  = seg1;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int model(int w, int op, int a, int b, int cin);
    case (op)
      0:       return a;
      1:       return (~(a & b)) & ((1 << w) - 1);
      2:       return a + b + cin;
      default: return a * b;
    endcase
  endfunction

  typedef struct {
    int res;
    int t0;
    int lat;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // Monitor: scoreboard pops on done, plus display scan/decode checks
  bit          pd     [2];
  int          prev_r [2];
  logic [2:0]  psel   [2];
  int          since  [2];
  bit          seen   [2];

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        pd[d]    = 1'b0;
        seen[d]  = 1'b0;
        since[d] = 0;
        psel[d]  = 3'd1;
        prev_r[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        int   sz;
        int   idx;
        int   nx;
        if (done_v[d]) begin
          chk($sformatf("d%0d done_width", d), int'(pd[d]), 0);
          sz = (d == 0) ? q0.size() : q1.size();
          chk($sformatf("d%0d spurious_done", d), int'(sz == 0), 0);
          if (sz != 0) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("d%0d result", d), int'(res_v[d]), e.res);
            chk($sformatf("d%0d latency", d), cyc - e.t0, e.lat);
          end
        end
        pd[d] = done_v[d];
        idx = 0;
        for (int k = DG[d] - 1; k >= 0; k--)
          if (sel_v[d][k]) idx = k;
        if (int'(res_v[d]) == prev_r[d])
          chk($sformatf("d%0d seg_data dig%0d", d, idx), int'(seg_v[d]),
              int'(SEG_TAB[(int'(res_v[d]) >> (4 * idx)) & 15]));
        prev_r[d] = int'(res_v[d]);
        since[d]++;
        if (sel_v[d] != psel[d]) begin
          if (seen[d]) begin
            nx = int'(psel[d]) << 1;
            if (nx >= (1 << DG[d])) nx = 1;
            chk($sformatf("d%0d scan_period", d), since[d], SD[d]);
            chk($sformatf("d%0d seg_sel", d), int'(sel_v[d]), nx);
          end
          seen[d]  = 1'b1;
          since[d] = 0;
        end
        psel[d] = sel_v[d];
      end
    end
  end

  task automatic issue(input int d, input int op, input int a,
                       input int b, input int cin, input bit push);
    int   n;
    exp_t e;
    n = 0;
    // While busy, scramble inputs and pulse start: all must be ignored
    while (busy_v[d] && n < 100) begin
      start_v[d] = 1'($urandom);
      op_v[d]    = 2'($urandom);
      a_v[d]     = 6'($urandom);
      b_v[d]     = 6'($urandom);
      cin_v[d]   = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("d%0d idle_wait", d), int'(busy_v[d]), 0);
    start_v[d] = 1'b1;
    op_v[d]    = 2'(op);
    a_v[d]     = 6'(a);
    b_v[d]     = 6'(b);
    cin_v[d]   = 1'(cin);
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    if (push) begin
      e.res = model(WD[d], op, a, b, cin);
      e.t0  = cyc;
      e.lat = (op == 3) ? WD[d] + 1 : 1;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic wait_digit(input int d, input int idx, input int exp);
    int n;
    n = 0;
    while (busy_v[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    start_v[d] = 1'b0;
    repeat (2) @(negedge clk);
    n = 0;
    while (sel_v[d] != 3'(1 << idx) && n < 4 * SD[d] * DG[d]) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d digit%0d", d, idx), int'(seg_v[d]), exp);
    @(posedge clk); #1;
  endtask

  task automatic rand_op(input int d);
    int m;
    m = (1 << WD[d]) - 1;
    issue(d, int'($urandom_range(0, 3)), int'($urandom) & m,
          int'($urandom) & m, int'($urandom_range(0, 1)), 1'b1);
    if ($urandom_range(0, 3) == 0) begin
      start_v[d] = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      op_v[d]    = '0;
      a_v[d]     = '0;
      b_v[d]     = '0;
      cin_v[d]   = 1'b0;
    end
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst busy", d), int'(busy_v[d]), 0);
      chk($sformatf("d%0d rst done", d), int'(done_v[d]), 0);
      chk($sformatf("d%0d rst result", d), int'(res_v[d]), 0);
      chk($sformatf("d%0d rst seg_sel", d), int'(sel_v[d]), 1);
      chk($sformatf("d%0d rst seg_data", d), int'(seg_v[d]), 8'h3F);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Abort a multiply mid-flight; no done may follow
    issue(0, 3, 15, 15, 0, 1'b0);
    @(posedge clk); #1;
    chk("d0 mul busy", int'(busy_v[0]), 1);
    rst = 1'b1;
    #1;
    chk("abort busy", int'(busy_v[0]), 0);
    chk("abort done", int'(done_v[0]), 0);
    chk("abort result", int'(res_v[0]), 0);
    chk("abort seg_sel", int'(sel_v[0]), 1);
    chk("abort seg_data", int'(seg_v[0]), 8'h3F);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(0, 0, 9, 0, 0, 1'b1);
    wait_digit(0, 0, 8'h6F);
    wait_digit(0, 1, 8'h3F);
    issue(0, 2, 15, 1, 1, 1'b1);
    issue(0, 1, 12, 10, 0, 1'b1);
    wait_digit(0, 0, 8'h07);
    issue(0, 3, 15, 15, 0, 1'b1);
    wait_digit(0, 0, 8'h06);
    wait_digit(0, 1, 8'h79);
    issue(0, 3, 0, 15, 0, 1'b1);

    // Start pulse during a multiply must be dropped
    issue(0, 3, 5, 7, 0, 1'b1);
    start_v[0] = 1'b1;
    op_v[0]    = 2'b00;
    a_v[0]     = 6'd3;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    issue(0, 0, 3, 0, 0, 1'b1);
    issue(0, 3, 9, 11, 1, 1'b1);
    issue(0, 2, 7, 8, 0, 1'b1);
    repeat (300) rand_op(0);

    for (int op = 0; op < 4; op++)
      for (int k = 0; k < 8; k++)
        issue(1, op, (k & 1) ? 63 : 0, (k & 2) ? 63 : 0, k >> 2, 1'b1);
    issue(1, 3, 63, 63, 0, 1'b1);
    wait_digit(1, 2, 8'h71);
    wait_digit(1, 1, 8'h7F);
    wait_digit(1, 0, 8'h06);
    issue(1, 2, 63, 63, 1, 1'b1);
    wait_digit(1, 2, 8'h3F);
    repeat (1200) rand_op(1);

    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (20) @(posedge clk);
    chk("d0 drained", q0.size(), 0);
    chk("d1 drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq_display.md
Name: alu_seq_display

Overview:
Parametrised, clocked successor of the lab's 2-bit combinational ALU and 7-segment readout. It registers operands on a start strobe and performs one of four operations: buffer, NAND, add-with-carry, or multiply. Multiply runs as a multi-cycle shift-add; the other operations complete in one cycle. The registered result is shown in hex on a time-multiplexed multi-digit 7-segment display, and the block sits directly between the board switches/buttons and the seven-segment header.

Parameters:
WIDTH, 4, operand width in bits (>=2).
SCAN_DIV, 1024, clock cycles each display digit stays selected (>=2).
Derived (localparam, not overridable): RW = 2*WIDTH result width; DIGITS = (RW+3)/4 hex digits shown.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
op  in  2  00 buffer a, 01 bitwise NAND, 10 add a+b+cin, 11 multiply a*b.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry-in, used by op 10 only.
busy  out  1  high while an operation is in progress (not IDLE).
done  out  1  one-cycle pulse when result updates.
result  out  RW  last completed result, zero-extended.
seg_sel  out  DIGITS  one-hot digit select, active-high, bit0 = least-significant nibble.
seg_data  out  8  segments {dp,g,f,e,d,c,b,a}, active-high, dp always 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; its polarity and synchronicity are fixed.
- Reset values: FSM=IDLE, busy=0, done=0, result=0, scan counter=0, digit index=0, seg_sel=1, seg_data=8'b00111111 (digit "0").
- Reset mid-operation: asynchronous abort to the reset values; no done pulse; the partial product is discarded.
- FSM states: IDLE, MUL, FIN.
- IDLE with start=1: latch a, b, cin, op.
  - op!=11: go to FIN.
  - op==11: clear the accumulator, set the iteration counter=0, go to MUL.
- IDLE with start=0: stay in IDLE.
- MUL, one iteration per cycle, WIDTH iterations:
  - If the multiplier LSB is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left and the multiplier right.
  - After iteration WIDTH-1, go to FIN.
- FIN: write result, assert done for this cycle only, return to IDLE.
- busy is high in MUL and FIN, low in IDLE.
- Latency from the start-sampling edge to the edge that raises done:
  - ops 00/01/10: 1 cycle.
  - op 11: WIDTH+1 cycles.
- Back-to-back operation: a new start is accepted on the cycle after done.
- start while busy is ignored and is not queued.
- Operand changes after the start is sampled have no effect on the running operation.
- Width rules:
  - Buffer: result = zero-extended a.
  - NAND: result = zero-extended ~(a&b), WIDTH bits.
  - Add: result = zero-extended (WIDTH+1)-bit sum; carry-out is result[WIDTH].
  - Multiply: full RW-bit product, no truncation; max (2^W-1)^2 fits.
- result holds its value between operations.
- Display scan counter:
  - Counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, digit index advances, wrapping DIGITS-1 -> 0.
  - seg_sel = one-hot of digit index.
- seg_data:
  - Registered hex decode of result nibble [4*idx+3:4*idx], updated on the same edge as seg_sel.
  - A top nibble narrower than 4 bits is zero-padded.
- Decode table:
  - 0=00111111, 1=00000110, 2=01011011, 3=01001111
  - 4=01100110, 5=01101101, 6=01111101, 7=00000111
  - 8=01111111, 9=01101111, A=01110111, b=01111100
  - C=00111001, d=01011110, E=01111001, F=01110001
- A result update mid-scan shows on the currently selected digit from the next edge; there is no tearing protection.

Test Plan:
- Reset and decode (WIDTH=4, SCAN_DIV=4): assert rst mid-MUL -> busy=0, result=0, seg_sel=01, seg_data=00111111 immediately, no done. Release rst, start op=00 a=4'h9 -> result=8'h09 with done one cycle later. Then scan -> seg_sel toggles every 4 cycles; data 01101111 on digit 0, 00111111 on digit 1.
- Add with carry: op=10, a=4'hF, b=4'h1, cin=1 -> done 1 cycle after start, result=8'h11.
- NAND: op=01, a=4'b1100, b=4'b1010 -> result=8'h07, seg_data on digit 0 = 00000111.
- Multiply extremes: op=11, a=4'hF, b=4'hF -> busy high for 5 cycles, done at start+5, result=8'hE1, digits show E (01111001) and 1 (00000110). Also a=0, b=4'hF -> result=0.
- Start while busy: during a multiply, pulse start with op=00 a=4'h3 -> ignored; only the multiply's done pulse occurs. A start on the cycle after done is accepted.
- Parameter sweep: WIDTH=6 exhaustive over all ops against a reference model. DIGITS=3; the top digit shows only 4 result bits. Check the latency formula WIDTH+1 for multiply.
